// File: rtl/uart_tx_cfg.sv
// Parametrised asynchronous serial transmitter.
// Width, parity and stop bits are set at elaboration; bit time comes from DIVISOR.
module uart_tx_cfg #(
    parameter int DIVISOR   = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 ready,
    output logic                 done
);

    localparam int CW = $clog2(DIVISOR);

    generate
        if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
            $error("uart_tx_cfg: DIVISOR out of range 2..65535");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS out of range 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_done;

    logic w_tick;
    logic w_par;

    assign w_tick = (r_baud == CW'(DIVISOR - 1));
    // Odd parity inverts the XOR so the total count of ones comes out odd.
    assign w_par  = (PARITY == 1) ? ~(^data) : (^data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_baud <= w_tick ? '0 : r_baud + 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (start && r_ready) begin
                        r_state <= S_START;
                        r_ready <= 1'b0;
                        r_tx    <= 1'b0;
                        r_shift <= data;
                        r_par   <= w_par;
                        r_bit   <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state <= S_DATA;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bit == 4'(DATA_BITS - 1)) begin
                            r_bit <= '0;
                            if (PARITY != 0) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 4'd1;
                            r_tx    <= r_shift[1];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_state <= S_STOP;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_bit == 4'(STOP_BITS - 1)) begin
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign tx    = r_tx;
    assign ready = r_ready;
    assign done  = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: six configurations checked cycle by cycle
// against a frame model built from the frame-format rules.
module tb_uart_tx_cfg;

    localparam int NI = 6;
    localparam int DIV[NI]   = '{4, 4, 4, 3, 2, 2};
    localparam int DBITS[NI] = '{8, 8, 8, 7, 5, 9};
    localparam int PAR[NI]   = '{0, 2, 1, 0, 0, 1};
    localparam int STOPS[NI] = '{1, 1, 1, 2, 1, 1};

    logic       clk;
    logic       rst;
    logic       st  [NI];
    logic [8:0] dt  [NI];
    logic       tx  [NI];
    logic       rdy [NI];
    logic       dn  [NI];

    int checks;
    int failures;

    uart_tx_cfg #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .start(st[0]), .data(dt[0][7:0]),
        .tx(tx[0]), .ready(rdy[0]), .done(dn[0]));
    uart_tx_cfg #(.DIVISOR(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .start(st[1]), .data(dt[1][7:0]),
        .tx(tx[1]), .ready(rdy[1]), .done(dn[1]));
    uart_tx_cfg #(.DIVISOR(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .start(st[2]), .data(dt[2][7:0]),
        .tx(tx[2]), .ready(rdy[2]), .done(dn[2]));
    uart_tx_cfg #(.DIVISOR(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .start(st[3]), .data(dt[3][6:0]),
        .tx(tx[3]), .ready(rdy[3]), .done(dn[3]));
    uart_tx_cfg #(.DIVISOR(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u4 (
        .clk(clk), .rst(rst), .start(st[4]), .data(dt[4][4:0]),
        .tx(tx[4]), .ready(rdy[4]), .done(dn[4]));
    uart_tx_cfg #(.DIVISOR(2), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u5 (
        .clk(clk), .rst(rst), .start(st[5]), .data(dt[5][8:0]),
        .tx(tx[5]), .ready(rdy[5]), .done(dn[5]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int flen(int i);
        return 1 + DBITS[i] + ((PAR[i] != 0) ? 1 : 0) + STOPS[i];
    endfunction

    // Bit k of the frame: start, data LSB first, optional parity, stops.
    function automatic logic exp_bit(int i, logic [8:0] v, int k);
        logic bits[$];
        int   ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int j = 0; j < DBITS[i]; j++) begin
            bits.push_back(v[j]);
            ones += int'(v[j]);
        end
        if (PAR[i] == 2) bits.push_back((ones % 2) == 1);
        if (PAR[i] == 1) bits.push_back((ones % 2) == 0);
        for (int s = 0; s < STOPS[i]; s++) bits.push_back(1'b1);
        return bits[k];
    endfunction

    task automatic accept(int i, logic [8:0] v);
        @(negedge clk);
        st[i] = 1'b1;
        dt[i] = v;
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after the accepting edge; leaves just after done.
    task automatic run_frame(int i, logic [8:0] v, bit keep, logic [8:0] nxt);
        int       n;
        logic [2:0] got;
        logic [2:0] want;
        n = flen(i) * DIV[i];
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c == 0 && !keep) st[i] = 1'b0;
            if (c == n / 2) begin
                dt[i] = nxt;
                if (!keep) st[i] = 1'b1;
            end
            if (c == n / 2 + 1 && !keep) st[i] = 1'b0;
            got  = {tx[i], rdy[i], dn[i]};
            want = {exp_bit(i, v, c / DIV[i]), 2'b00};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL frame u%0d data=%h cyc=%0d tx/rdy/done got=%b want=%b",
                         i, v, c, got, want);
            end
        end
        @(posedge clk);
        #1;
        got = {tx[i], rdy[i], dn[i]};
        checks++;
        if (got !== 3'b111) begin
            failures++;
            $display("FAIL done u%0d data=%h tx/rdy/done got=%b want=111", i, v, got);
        end
    endtask

    task automatic idle_check(int i, int cycles);
        logic [2:0] got;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            got = {tx[i], rdy[i], dn[i]};
            checks++;
            if (got !== 3'b110) begin
                failures++;
                $display("FAIL idle u%0d cyc=%0d tx/rdy/done got=%b want=110", i, k, got);
            end
        end
    endtask

    task automatic one_frame(int i, logic [8:0] v);
        accept(i, v);
        run_frame(i, v, 1'b0, 9'($urandom_range(0, 511)));
        idle_check(i, 2);
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            st[i] = 1'b0;
            dt[i] = '0;
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            got = {tx[i], rdy[i], dn[i]};
            checks++;
            if (got !== 3'b110) begin
                failures++;
                $display("FAIL reset u%0d tx/rdy/done got=%b want=110", i, got);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_check(0, 3);
    endtask

    task automatic test_8n1();
        one_frame(0, 9'h055);
        for (int r = 0; r < 3; r++) one_frame(0, 9'($urandom_range(0, 255)));
    endtask

    task automatic test_parity();
        one_frame(1, 9'h007);
        one_frame(2, 9'h055);
        one_frame(1, 9'h055);
        for (int r = 0; r < 2; r++) begin
            one_frame(1, 9'($urandom_range(0, 255)));
            one_frame(2, 9'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_7n2();
        one_frame(3, 9'h07F);
        one_frame(3, 9'h0FF);
        one_frame(3, 9'($urandom_range(0, 511)));
    endtask

    task automatic test_corner_widths();
        one_frame(5, 9'h1FF);
        for (int r = 0; r < 3; r++) begin
            one_frame(4, 9'($urandom_range(0, 511)));
            one_frame(5, 9'($urandom_range(0, 511)));
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] a;
        logic [8:0] b;
        for (int i = 0; i < 2; i++) begin
            a = 9'($urandom_range(0, 255));
            b = 9'($urandom_range(0, 255));
            accept(i, a);
            run_frame(i, a, 1'b1, b);
            @(posedge clk);
            #1;
            run_frame(i, b, 1'b0, 9'($urandom_range(0, 255)));
            idle_check(i, 3);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] got;
        accept(0, 9'h052);
        st[0] = 1'b0;
        repeat (17) @(posedge clk);
        #3;
        checks++;
        if (tx[0] !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_bit3 tx got=%b want=0", tx[0]);
        end
        rst = 1'b1;
        #1;
        got = {tx[0], rdy[0], dn[0]};
        checks++;
        if (got !== 3'b110) begin
            failures++;
            $display("FAIL async_reset tx/rdy/done got=%b want=110", got);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_check(0, 6);
        one_frame(0, 9'($urandom_range(0, 255)));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_corner_widths();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
